// File: rtl/mem_dump_ctrl.sv
// Debug memory dump controller: walks the data memory word by word and streams each word
// to the UART transmitter MSB byte first, stalling the memory stage while it owns the port.
module mem_dump_ctrl #(
  parameter int unsigned WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] mem_data,
  output logic [31:0] dir_mem_db,
  output logic        lector_db,
  output logic        stall_db,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LastAddr = 6'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCapture,
    StSend,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  // Abort wins over a concurrent byte handshake, so an aborted byte is never counted.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAddr;
          addr_d     = '0;
          byte_idx_d = '0;
        end
      end
      StAddr: begin
        if (abort) begin
          state_d = StIdle;
          addr_d  = '0;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (abort) begin
          state_d = StIdle;
          addr_d  = '0;
        end else begin
          word_d     = mem_data;
          byte_idx_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          state_d    = StIdle;
          addr_d     = '0;
          byte_idx_d = '0;
        end else if (tx_ready) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else if (addr_q != LastAddr) begin
            addr_d     = addr_q + 6'd1;
            byte_idx_d = '0;
            state_d    = StAddr;
          end else begin
            addr_d     = '0;
            byte_idx_d = '0;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    dir_mem_db = '0;
    lector_db  = 1'b0;
    stall_db   = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    if (state_q == StAddr || state_q == StCapture || state_q == StSend) begin
      dir_mem_db = {26'b0, addr_q};
      lector_db  = 1'b1;
      stall_db   = 1'b1;
    end
    if (state_q == StSend) begin
      tx_valid = 1'b1;
      unique case (byte_idx_q)
        2'd0: tx_data = word_q[31:24];
        2'd1: tx_data = word_q[23:16];
        2'd2: tx_data = word_q[15:8];
        2'd3: tx_data = word_q[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: byte-stream reference model with per-cycle compare, directed
// scenarios with literal expectations, a WORDS=2 sequence check and a randomized phase.
module tb_mem_dump_ctrl;

  localparam int unsigned WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] dir_mem_db;
  logic        lector_db, stall_db, tx_valid, busy, done;
  logic [7:0]  tx_data;

  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic        tx_ready2 = 1'b1;
  logic [31:0] mem_data2 = '0;
  logic [31:0] dir2;
  logic        lector2, stall2, valid2, busy2, done2;
  logic [7:0]  tx_data2;

  logic [31:0] mem  [64];
  logic [31:0] mem2 [2];

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int busy_gap = 0;
  bit in_dump = 1'b0;
  logic [7:0] rx_q [$];

  // Reference model: dump active, bytes accepted so far, fetch cycles left before the next offer.
  bit m_act = 1'b0;
  bit m_done = 1'b0;
  int m_n = 0;
  int m_gap = 0;

  always #5 clk = ~clk;

  mem_dump_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mem_data(mem_data),
    .dir_mem_db(dir_mem_db), .lector_db(lector_db), .stall_db(stall_db), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  mem_dump_ctrl #(.WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .mem_data(mem_data2),
    .dir_mem_db(dir2), .lector_db(lector2), .stall_db(stall2), .tx_data(tx_data2),
    .tx_valid(valid2), .tx_ready(tx_ready2), .busy(busy2), .done(done2)
  );

  always @(negedge clk) begin
    mem_data  <= mem[dir_mem_db[5:0]];
    mem_data2 <= mem2[dir2[0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = mem[n / 4] >> (8 * (3 - (n % 4)));
    return w[7:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_n    <= 0;
      m_gap  <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_n   <= 0;
        m_gap <= 2;
      end
    end else if (abort) begin
      m_act <= 1'b0;
    end else if (m_gap > 0) begin
      m_gap <= m_gap - 1;
    end else if (tx_ready) begin
      if (m_n == int'(4 * WORDS) - 1) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_n   <= m_n + 1;
        m_gap <= ((m_n + 1) % 4 == 0) ? 2 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_act | m_done));
      chk("stall_db", 32'(stall_db), 32'(m_act));
      chk("lector_db", 32'(lector_db), 32'(m_act));
      chk("dir_mem_db", dir_mem_db, m_act ? 32'(m_n / 4) : 32'd0);
      chk("tx_valid", 32'(tx_valid), 32'(m_act && m_gap == 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_act && m_gap == 0) chk("tx_data", 32'(tx_data), 32'(exp_byte(m_n)));
      if (tx_valid && tx_ready && !abort) rx_q.push_back(tx_data);
      if (done) done_cnt++;
      if (in_dump && !busy) busy_gap++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq_t [14];
  logic [7:0] bytes2 [8];

  initial begin
    int sidx;
    int stall_cnt;
    bit exp_stall;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem2[0] = 32'h11223344;
    mem2[1] = 32'h55667788;
    seq_t  = '{1, 2, 3, 3, 3, 3, 1, 2, 3, 3, 3, 3, 4, 0};
    bytes2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Reset state
    step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst stall", 32'(stall_db), 32'd0);
    chk("rst lector", 32'(lector_db), 32'd0);
    chk("rst dir", dir_mem_db, 32'd0);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst done", 32'(done), 32'd0);

    // Single nonzero word, ready always high; start honoured on the first edge after reset
    mem[4] = 32'h0000000C;
    tx_ready = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    busy_gap = 0;
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    in_dump = 1'b1;
    chk("first start busy", 32'(busy), 32'd1);
    chk("first start dir", dir_mem_db, 32'd0);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) step();
    in_dump = 1'b0;
    step();
    chk("full dump byte count", 32'(rx_q.size()), 32'd256);
    chk("byte16", 32'(rx_q[16]), 32'h00);
    chk("byte17", 32'(rx_q[17]), 32'h00);
    chk("byte18", 32'(rx_q[18]), 32'h00);
    chk("byte19", 32'(rx_q[19]), 32'h0C);
    chk("full dump done pulses", 32'(done_cnt), 32'd1);
    chk("busy gaps in dump", 32'(busy_gap), 32'd0);

    // Backpressure holds the first byte stable
    mem[4] = '0;
    mem[0] = 32'hA1B2C3D4;
    rx_q.delete();
    tx_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !tx_valid; i++) step();
    chk("reach send", 32'(tx_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("hold tx_valid", 32'(tx_valid), 32'd1);
      chk("hold tx_data", 32'(tx_data), 32'hA1);
      step();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() < 4; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("bp byte count", 32'(rx_q.size()), 32'd4);
    chk("bp byte0", 32'(rx_q[0]), 32'hA1);
    chk("bp byte1", 32'(rx_q[1]), 32'hB2);
    chk("bp byte2", 32'(rx_q[2]), 32'hC3);
    chk("bp byte3", 32'(rx_q[3]), 32'hD4);
    chk("bp abort idle", 32'(busy), 32'd0);

    // Restart attempt mid-dump is ignored
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rx_q.delete();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300 && dir_mem_db != 32'd10; i++) step();
    chk("reach addr 10", dir_mem_db, 32'd10);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) step();
    step();
    chk("restart byte count", 32'(rx_q.size()), 32'd256);
    chk("restart done pulses", 32'(done_cnt), 32'd1);

    // Abort at addr 7, byte 2 together with a handshake
    rx_q.delete();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300 && !(rx_q.size() == 30 && tx_valid); i++) step();
    chk("reach addr7 byte2", 32'(rx_q.size()), 32'd30);
    chk("abort point dir", dir_mem_db, 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort stall", 32'(stall_db), 32'd0);
    chk("abort lector", 32'(lector_db), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    step();
    step();
    chk("abort byte not sent", 32'(rx_q.size()), 32'd30);
    chk("abort no done pulse", 32'(done_cnt), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post-abort start dir", dir_mem_db, 32'd0);
    chk("post-abort start stall", 32'(stall_db), 32'd1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Asynchronous reset in CAPTURE
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("capture stall", 32'(stall_db), 32'd1);
    chk("capture tx_valid", 32'(tx_valid), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst stall", 32'(stall_db), 32'd0);
    chk("async rst lector", 32'(lector_db), 32'd0);
    chk("async rst dir", dir_mem_db, 32'd0);
    chk("async rst tx_valid", 32'(tx_valid), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("async rst no done", 32'(done_cnt), 32'd0);

    // WORDS=2 full sequence, every cycle
    chk("w2 idle before", 32'(busy2), 32'd0);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    sidx = 0;
    stall_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      exp_stall = (seq_t[i] >= 1 && seq_t[i] <= 3);
      chk("w2 busy", 32'(busy2), 32'(seq_t[i] != 0));
      chk("w2 stall", 32'(stall2), 32'(exp_stall));
      chk("w2 lector", 32'(lector2), 32'(exp_stall));
      chk("w2 tx_valid", 32'(valid2), 32'(seq_t[i] == 3));
      chk("w2 done", 32'(done2), 32'(seq_t[i] == 4));
      chk("w2 dir", dir2, exp_stall ? ((i < 6) ? 32'd0 : 32'd1) : 32'd0);
      if (seq_t[i] == 3) begin
        chk("w2 tx_data", 32'(tx_data2), 32'(bytes2[sidx]));
        sidx++;
      end
      if (stall2) stall_cnt++;
      step();
    end
    chk("w2 stall cycles", 32'(stall_cnt), 32'd12);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 39) == 0);
      abort    = ($urandom_range(0, 1499) == 0);
      if (!busy) mem[$urandom_range(0, 63)] = $urandom;
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 2000 && busy; i++) step();
    chk("random phase drains", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
